// File: rtl/int_ack_responder_if.sv
// Peripheral bus bundle between the 68000-side master and the IACK responder.
// Carries both the register-window accesses and the interrupt-acknowledge cycles.
interface int_ack_responder_if;
  logic        as;
  logic [2:0]  fc;
  logic [7:0]  addr;
  logic        rw;
  logic        uds;
  logic        lds;
  logic        sel;
  logic [15:0] data_write;
  logic [2:0]  ipl_n;
  logic [15:0] data_read;
  logic        ack;
  logic        vpa;
  logic [6:0]  int_clear;

  modport master (
    output as, fc, addr, rw, uds, lds, sel, data_write, ipl_n,
    input  data_read, ack, vpa, int_clear
  );

  modport slave (
    input  as, fc, addr, rw, uds, lds, sel, data_write, ipl_n,
    output data_read, ack, vpa, int_clear
  );
endinterface

// File: rtl/int_ack_responder.sv
// Answers 68000 IACK cycles with an autovector request or a programmable vector,
// and serves a small register window for vector programming and status.
module int_ack_responder #(
  parameter logic [7:0] SPURIOUS_VECTOR = 8'd24,
  parameter logic [6:0] AUTOVEC_RESET   = 7'h7F
) (
  input  logic              clk,
  input  logic              reset,
  int_ack_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic        iack_q, iack_d;
  logic        rw_q, rw_d;
  logic        lds_q, lds_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [2:0]  ipl_n_q, ipl_n_d;

  logic [7:0]  vec_q [7];
  logic [7:0]  vec_d [7];
  logic [6:0]  autovec_q, autovec_d;
  logic [7:0]  spur_cnt_q, spur_cnt_d;
  logic [2:0]  last_level_q, last_level_d;

  logic        ack_q, ack_d;
  logic        vpa_q, vpa_d;
  logic [15:0] data_read_q, data_read_d;
  logic [6:0]  int_clear_q, int_clear_d;

  logic [7:0]  reg_rdata_s;
  logic [2:0]  iack_level_s;
  logic [2:0]  req_level_s;

  assign iack_level_s = idx_q[2:0];
  assign req_level_s  = ~ipl_n_q;

  // Register-window read mux.
  always_comb begin
    reg_rdata_s = 8'd0;
    if (idx_q < 7'd7) begin
      reg_rdata_s = vec_q[idx_q[2:0]];
    end else begin
      case (idx_q)
        7'd7:    reg_rdata_s = {1'b0, autovec_q};
        7'd8:    reg_rdata_s = spur_cnt_q;
        7'd9:    reg_rdata_s = {5'd0, last_level_q};
        default: reg_rdata_s = 8'd0;
      endcase
    end
  end

  // Next-state, register updates and one-cycle responses.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    iack_d       = iack_q;
    rw_d         = rw_q;
    lds_d        = lds_q;
    wdata_d      = wdata_q;
    ipl_n_d      = ipl_n_q;
    vec_d        = vec_q;
    autovec_d    = autovec_q;
    spur_cnt_d   = spur_cnt_q;
    last_level_d = last_level_q;
    ack_d        = 1'b0;
    vpa_d        = 1'b0;
    data_read_d  = 16'd0;
    int_clear_d  = 7'd0;

    case (state_q)
      IDLE: begin
        if (bus.as && ((bus.fc == 3'b111) || bus.sel)) begin
          idx_d   = bus.addr[7:1];
          iack_d  = (bus.fc == 3'b111);
          rw_d    = bus.rw;
          lds_d   = bus.lds;
          wdata_d = bus.data_write[7:0];
          ipl_n_d = bus.ipl_n;
          state_d = DECODE;
        end else begin
          state_d = IDLE;
        end
      end

      DECODE: begin
        state_d = RELEASE;
        if (iack_q) begin
          if ((iack_level_s == 3'd0) || (iack_level_s != req_level_s)) begin
            ack_d       = 1'b1;
            data_read_d = {8'd0, SPURIOUS_VECTOR};
            if (spur_cnt_q != 8'hFF) begin
              spur_cnt_d = spur_cnt_q + 8'd1;
            end else begin
              spur_cnt_d = spur_cnt_q;
            end
          end else begin
            int_clear_d  = 7'(7'd1 << (iack_level_s - 3'd1));
            last_level_d = iack_level_s;
            if (autovec_q[iack_level_s - 3'd1]) begin
              vpa_d = 1'b1;
            end else begin
              ack_d       = 1'b1;
              data_read_d = {8'd0, vec_q[iack_level_s - 3'd1]};
            end
          end
        end else begin
          ack_d = 1'b1;
          if (rw_q) begin
            data_read_d = {8'd0, (lds_q ? reg_rdata_s : 8'd0)};
          end else if (lds_q) begin
            // Writes to read-only or unmapped indices are acked but discarded.
            if (idx_q < 7'd7) begin
              vec_d[idx_q[2:0]] = wdata_q;
            end else begin
              case (idx_q)
                7'd7:    autovec_d  = wdata_q[6:0];
                7'd8:    spur_cnt_d = 8'd0;
                default: spur_cnt_d = spur_cnt_q;
              endcase
            end
          end else begin
            data_read_d = 16'd0;
          end
        end
      end

      RELEASE: begin
        if (!bus.as) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end

      default: state_d = RELEASE;
    endcase
  end

  // State and register file; reset parks in RELEASE so an in-flight cycle is skipped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RELEASE;
      idx_q        <= 7'd0;
      iack_q       <= 1'b0;
      rw_q         <= 1'b0;
      lds_q        <= 1'b0;
      wdata_q      <= 8'd0;
      ipl_n_q      <= 3'b111;
      for (int i = 0; i < 7; i++) begin
        vec_q[i] <= 8'h41 + 8'(i);
      end
      autovec_q    <= AUTOVEC_RESET;
      spur_cnt_q   <= 8'd0;
      last_level_q <= 3'd0;
      ack_q        <= 1'b0;
      vpa_q        <= 1'b0;
      data_read_q  <= 16'd0;
      int_clear_q  <= 7'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      iack_q       <= iack_d;
      rw_q         <= rw_d;
      lds_q        <= lds_d;
      wdata_q      <= wdata_d;
      ipl_n_q      <= ipl_n_d;
      vec_q        <= vec_d;
      autovec_q    <= autovec_d;
      spur_cnt_q   <= spur_cnt_d;
      last_level_q <= last_level_d;
      ack_q        <= ack_d;
      vpa_q        <= vpa_d;
      data_read_q  <= data_read_d;
      int_clear_q  <= int_clear_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.vpa       = vpa_q;
  assign bus.data_read = data_read_q;
  assign bus.int_clear = int_clear_q;

endmodule

// File: tb/tb_int_ack_responder.sv
// Scoreboard bench for int_ack_responder: each access pushes its expected response,
// a negedge monitor pops and compares whenever the DUT answers.
module tb_int_ack_responder;

  logic clk;
  logic reset;
  int   checks;
  int   fails;
  logic [24:0] exp_q [$];

  int_ack_responder_if bif ();

  int_ack_responder #(
    .SPURIOUS_VECTOR(8'd24),
    .AUTOVEC_RESET  (7'h7F)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response packing: {ack, vpa, int_clear[6:0], data_read[15:0]}
  function automatic logic [24:0] mk(input logic a, input logic v, input logic [6:0] c,
                                     input logic [15:0] d);
    return {a, v, c, d};
  endfunction

  // Monitor: every response pops one expectation; idle cycles must show zero data.
  always @(negedge clk) begin
    logic [24:0] got;
    logic [24:0] e;
    got = {bif.ack, bif.vpa, bif.int_clear, bif.data_read};
    if (bif.ack || bif.vpa || (bif.int_clear != 7'd0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_response t=%0t got ack=%0b vpa=%0b clr=%b data=%h, required none",
                 $time, bif.ack, bif.vpa, bif.int_clear, bif.data_read);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          fails++;
          $display("FAIL response t=%0t got ack=%0b vpa=%0b clr=%b data=%h, required ack=%0b vpa=%0b clr=%b data=%h",
                   $time, got[24], got[23], got[22:16], got[15:0], e[24], e[23], e[22:16], e[15:0]);
        end
      end
    end else begin
      checks++;
      if (bif.data_read !== 16'd0) begin
        fails++;
        $display("FAIL idle_data t=%0t got %h, required 0000", $time, bif.data_read);
      end
    end
  end

  task automatic bus_idle();
    bif.as = 1'b0; bif.fc = 3'b000; bif.addr = 8'd0; bif.rw = 1'b1;
    bif.uds = 1'b0; bif.lds = 1'b0; bif.sel = 1'b0; bif.data_write = 16'd0;
  endtask

  // One bus cycle: as high for `hold` clocks, then one as-low clock.
  task automatic access(input bit iack, input logic [7:0] a, input bit rd, input bit l,
                        input logic [15:0] wd, input logic [2:0] ipl, input logic [2:0] ipl_late,
                        input int hold, input bit expect_resp, input logic [24:0] e);
    @(negedge clk);
    bif.as = 1'b1; bif.fc = iack ? 3'b111 : 3'b001; bif.sel = !iack;
    bif.addr = a; bif.rw = rd; bif.lds = l; bif.uds = 1'b0; bif.data_write = wd;
    bif.ipl_n = ipl;
    if (expect_resp) exp_q.push_back(e);
    @(negedge clk);
    bif.ipl_n = ipl_late;
    repeat (hold - 1) @(negedge clk);
    bus_idle();
    @(negedge clk);
  endtask

  task automatic rd_reg(input int idx, input logic [7:0] v);
    access(1'b0, 8'(idx << 1), 1'b1, 1'b1, 16'd0, 3'b111, 3'b111, 2, 1'b1, mk(1'b1, 1'b0, 7'd0, {8'd0, v}));
  endtask

  task automatic wr_reg(input int idx, input logic [7:0] v, input bit l);
    access(1'b0, 8'(idx << 1), 1'b0, l, {8'hA5, v}, 3'b111, 3'b111, 2, 1'b1, mk(1'b1, 1'b0, 7'd0, 16'd0));
  endtask

  task automatic iack(input int lvl, input logic [2:0] ipl, input logic [24:0] e);
    access(1'b1, 8'(lvl << 1), 1'b1, 1'b1, 16'd0, ipl, ipl, 2, 1'b1, e);
  endtask

  task automatic wait_drain(output int left);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    left = exp_q.size();
    exp_q.delete();
  endtask

  task automatic test_reset();
    int left;
    reset = 1'b1;
    bus_idle();
    bif.ipl_n = 3'b111;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bif.ack, bif.vpa, bif.int_clear, bif.data_read} !== 25'd0) begin
      fails++;
      $display("FAIL reset_outputs got %h, required 0", {bif.ack, bif.vpa, bif.int_clear, bif.data_read});
    end
    for (int i = 0; i < 7; i++) rd_reg(i, 8'h41 + 8'(i));
    rd_reg(7, 8'h7F);
    rd_reg(8, 8'h00);
    rd_reg(9, 8'h00);
    rd_reg(10, 8'h00);
    wr_reg(12, 8'hFF, 1'b1);
    wait_drain(left);
    checks++;
    if (left !== 0) begin fails++; $display("FAIL reset_drain got %0d pending, required 0", left); end
  endtask

  task automatic test_autovector();
    int left;
    iack(1, 3'b110, mk(1'b0, 1'b1, 7'b0000001, 16'd0));
    rd_reg(9, 8'd1);
    wait_drain(left);
    checks++;
    if (left !== 0) begin fails++; $display("FAIL autovec_drain got %0d pending, required 0", left); end
  endtask

  task automatic test_vectored();
    int left;
    wr_reg(7, 8'h7E, 1'b1);
    wr_reg(0, 8'h80, 1'b1);
    wr_reg(0, 8'h33, 1'b0);
    rd_reg(0, 8'h80);
    iack(1, 3'b110, mk(1'b1, 1'b0, 7'b0000001, 16'h0080));
    iack(3, 3'b100, mk(1'b0, 1'b1, 7'b0000100, 16'd0));
    rd_reg(9, 8'd3);
    wait_drain(left);
    checks++;
    if (left !== 0) begin fails++; $display("FAIL vectored_drain got %0d pending, required 0", left); end
  endtask

  task automatic test_spurious();
    int left;
    iack(2, 3'b111, mk(1'b1, 1'b0, 7'd0, 16'h0018));
    rd_reg(8, 8'd1);
    iack(0, 3'b111, mk(1'b1, 1'b0, 7'd0, 16'h0018));
    rd_reg(8, 8'd2);
    rd_reg(9, 8'd3);
    for (int i = 0; i < 300; i++) iack(2, 3'b111, mk(1'b1, 1'b0, 7'd0, 16'h0018));
    rd_reg(8, 8'd255);
    wr_reg(8, 8'h00, 1'b1);
    rd_reg(8, 8'd0);
    wait_drain(left);
    checks++;
    if (left !== 0) begin fails++; $display("FAIL spurious_drain got %0d pending, required 0", left); end
  endtask

  task automatic test_long_as();
    int left;
    access(1'b0, 8'd2, 1'b1, 1'b1, 16'd0, 3'b111, 3'b111, 10, 1'b1, mk(1'b1, 1'b0, 7'd0, 16'h0042));
    wait_drain(left);
    checks++;
    if (left !== 0) begin fails++; $display("FAIL long_as_drain got %0d pending, required 0", left); end
  endtask

  task automatic test_reset_mid();
    int left;
    @(negedge clk);
    bif.as = 1'b1; bif.fc = 3'b111; bif.addr = 8'd2; bif.rw = 1'b1; bif.lds = 1'b1;
    bif.ipl_n = 3'b110;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({bif.ack, bif.vpa, bif.int_clear} !== 9'd0) begin
      fails++;
      $display("FAIL reset_mid_quiet got %b, required 0", {bif.ack, bif.vpa, bif.int_clear});
    end
    bus_idle();
    @(negedge clk);
    rd_reg(0, 8'h41);
    rd_reg(7, 8'h7F);
    wait_drain(left);
    checks++;
    if (left !== 0) begin fails++; $display("FAIL reset_mid_drain got %0d pending, required 0", left); end
  endtask

  task automatic test_ipl_change();
    int left;
    access(1'b1, 8'd2, 1'b1, 1'b1, 16'd0, 3'b110, 3'b111, 2, 1'b1, mk(1'b0, 1'b1, 7'b0000001, 16'd0));
    rd_reg(8, 8'd0);
    wait_drain(left);
    checks++;
    if (left !== 0) begin fails++; $display("FAIL ipl_change_drain got %0d pending, required 0", left); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_autovector();
    test_vectored();
    test_spurious();
    test_long_as();
    test_reset_mid();
    test_ipl_change();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/int_ack_responder.md
# int_ack_responder

Answers the 68000 interrupt-acknowledge (IACK) bus cycle raised in response to the `ipl_n` level driven by the interrupt controller. Per level, it either requests an autovector via `vpa` or supplies a programmable 8-bit vector number on `data_read` with `ack`. It emits a one-cycle per-level clear pulse and counts spurious acknowledges. It also exposes a small register window on the same peripheral bus for vector programming and status.

## Interface
Parameters:
- `SPURIOUS_VECTOR`, default 8'd24: vector returned for a spurious IACK.
- `AUTOVEC_RESET`, default 7'h7F: reset value of the autovector-enable register; bit n-1 corresponds to level n.

Ports:
- `clk` in 1: single clock; everything is synchronous to its rising edge.
- `reset` in 1: synchronous, active-high.
- `as` in 1: address strobe, active-high.
- `fc` in 3: CPU function code; 3'b111 marks an IACK cycle.
- `addr` in 8: byte address. During IACK, `addr[3:1]` carries the acknowledged level.
- `rw` in 1: 1 = read, 0 = write.
- `uds`, `lds` in 1 each: upper/lower byte strobes, active-high.
- `sel` in 1: register-window chip select; ignored when `fc`==3'b111.
- `data_write` in 16: write data.
- `ipl_n` in 3: current level request from the interrupt controller; requested level = ~`ipl_n`.
- `data_read` out 16: read / vector data; 0 whenever `ack` is low.
- `ack` out 1: one-cycle transfer acknowledge.
- `vpa` out 1: one-cycle autovector request.
- `int_clear` out 7: one-cycle pulse; bit n-1 clears level n at its source.

## Operation
Register window (`sel`=1, `fc`!=7). Word index is `addr[7:1]`. All data sits in the low byte, gated by `lds`. Reads with `uds` return 0 in [15:8].
- Index 0..6: `vec[1..7]`, RW, reset 8'h40+level (levels 1..7 → 0x41..0x47).
- Index 7: `autovec_en[6:0]`, RW, reset `AUTOVEC_RESET`.
- Index 8: `spurious_cnt[7:0]`, RO, saturates at 255. Any write with `lds` clears it.
- Index 9: `last_level[2:0]`, RO, reset 0.
- Index ≥10: acked; reads return 0; writes are ignored.

IACK decision, taken on the latched cycle `L` = `addr[3:1]`, `R` = ~`ipl_n`:
- **Spurious** (`L`==0 or `L`!=`R`): drive `ack`, `data_read`=`SPURIOUS_VECTOR`, increment `spurious_cnt` (saturating). No `int_clear`; `last_level` unchanged.
- **Autovector** (`autovec_en[L-1]`=1): drive `vpa`; `ack`=0; `data_read`=0.
- **Vectored**: drive `ack`, `data_read`={8'd0, `vec[L]`}.
- Both autovector and vectored cases pulse `int_clear[L-1]` and set `last_level`=`L`.

FSM states:
- **IDLE**: if `as` && (`fc`==7 || `sel`), latch `addr`/`fc`/`rw`/`uds`/`lds`/`data_write`/`ipl_n` → DECODE. Otherwise stay.
- **DECODE**: perform the register write or IACK decision; register `ack`/`vpa`/`data_read`/`int_clear` → RELEASE.
- **RELEASE**: hold outputs low; when `as` is sampled low → IDLE.
- `as` dropping during DECODE: the response still fires once, then RELEASE exits on the next edge.

## Timing
- Edge E0 samples `as` high in IDLE.
- Edge E1: register writes take effect; `ack`/`vpa`/`data_read`/`int_clear` go high for exactly one cycle (E1→E2).
- Latency from `as` sample to response is 2 edges. Minimum bus cycle length is 3 clocks including one `as`-low cycle.
- `ipl_n` is sampled only at E0; later changes do not alter the decision.
- Reset: `ack`=0, `vpa`=0, `int_clear`=0, `data_read`=0, registers at reset values, FSM = RELEASE. A cycle already in flight at reset release is not answered; the FSM enters IDLE only after `as` is seen low.
- `ack` and `vpa` are never high in the same cycle. At most one `int_clear` bit is high in any cycle.
- Spurious counter at 255 plus another spurious IACK stays 255. A clear-write and a spurious event cannot coincide, because accesses are serialized by the FSM.

## Test plan
- Reset, then read index 0..9 → 0x41..0x47, 0x7F, 0, 0. `ack` high for exactly 1 cycle per access.
- `ipl_n`=3'b110, IACK with `addr[3:1]`=1, default config → `vpa` pulse at E1, `int_clear`=7'b0000001, `ack`=0, `last_level`=1.
- Write `autovec_en`=0x7E and `vec[1]`=0x80; IACK level 1 → `ack` with `data_read`=0x0080, `int_clear[0]` pulse.
- `ipl_n`=3'b111, IACK level 2 → `ack`, `data_read`=0x0018, `spurious_cnt`=1, no `int_clear`. After 300 such cycles the counter reads 255; a write to index 8 then reads 0.
- Hold `as` high for 10 cycles → exactly one response. Assert `reset` mid-cycle with `as` still high → no response until `as` drops and rises again.
- `ipl_n` changes from 3'b110 to 3'b111 one cycle after E0 of a level-1 IACK → non-spurious response (`vpa`, `int_clear[0]`).
